// File: rtl/ula_pkg.sv
// ula_pkg: opcode encoding shared by the ULA core and its register wrapper
package ula_pkg;
  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_NOTA = 3'b010,
    OP_NAND = 3'b011,
    OP_ADD  = 3'b100,
    OP_SUB  = 3'b101,
    OP_LSL  = 3'b110,
    OP_LSR  = 3'b111
  } ula_op_e;
endpackage

// File: rtl/ula_core.sv
// ula_core: combinational ALU datapath, one adder shared between ADD and SUB
import ula_pkg::*;
module ula_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       s,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic             v
);
  ula_op_e          op;
  logic             sub;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;
  logic             ovf;
  assign op  = ula_op_e'(s);
  assign sub = (op == OP_SUB);
  assign bx  = sub ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
  // Overflow when both adder inputs agree in sign and the sum disagrees; holds for SUB via inverted B
  assign ovf = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  assign y = (op == OP_AND)  ? a & b :
             (op == OP_OR)   ? a | b :
             (op == OP_NOTA) ? ~a :
             (op == OP_NAND) ? ~(a & b) :
             (op == OP_LSL)  ? {a[WIDTH-2:0], 1'b0} :
             (op == OP_LSR)  ? {1'b0, a[WIDTH-1:1]} :
             sum[WIDTH-1:0];
  assign c = (op == OP_ADD) ? sum[WIDTH] :
             (op == OP_SUB) ? ~sum[WIDTH] :
             (op == OP_LSL) ? a[WIDTH-1] :
             (op == OP_LSR) ? a[0] :
             1'b0;
  assign v = (op == OP_ADD || op == OP_SUB) ? ovf : 1'b0;
endmodule

// File: rtl/ula_dataflow.sv
// ula_dataflow: registered ALU with zero/negative/carry/overflow flags
import ula_pkg::*;
module ula_dataflow #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       S,
  output logic [WIDTH-1:0] R,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V
);
  logic [WIDTH-1:0] y, r_d, r_q;
  logic             c, v, z_d, z_q, n_d, n_q, c_d, c_q, v_d, v_q;
  ula_core #(.WIDTH(WIDTH)) u_core (.a(A), .b(B), .s(S), .y(y), .c(c), .v(v));
  always_comb begin
    r_d = en ? y : r_q;
    z_d = en ? (y == '0) : z_q;
    n_d = en ? y[WIDTH-1] : n_q;
    c_d = en ? c : c_q;
    v_d = en ? v : v_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
      z_q <= 1'b0;
      n_q <= 1'b0;
      c_q <= 1'b0;
      v_q <= 1'b0;
    end else begin
      r_q <= r_d;
      z_q <= z_d;
      n_q <= n_d;
      c_q <= c_d;
      v_q <= v_d;
    end
  end
  assign R = r_q;
  assign Z = z_q;
  assign N = n_q;
  assign C = c_q;
  assign V = v_q;
endmodule

// File: tb/tb_ula_dataflow.sv
// tb_ula_dataflow: directed vector table plus reset/hold sequences for ula_dataflow
module tb_ula_dataflow;
  typedef struct {
    logic [2:0] s;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] r;
    logic       z, n, c, v;
  } vec_t;
  logic       clk = 1'b0, rst = 1'b0, en = 1'b0;
  logic [3:0] A = 4'h0, B = 4'h0, R;
  logic [2:0] S = 3'b000;
  logic       Z, N, C, V;
  int         checks = 0, failures = 0;
  vec_t       tbl [14];
  ula_dataflow #(.WIDTH(4)) dut (.clk(clk), .rst(rst), .en(en), .A(A), .B(B), .S(S),
                                 .R(R), .Z(Z), .N(N), .C(C), .V(V));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [3:0] r, input logic z, input logic n,
                       input logic c, input logic v);
    checks++;
    if ({R, Z, N, C, V} !== {r, z, n, c, v}) begin
      failures++;
      $display("FAIL %s: got R=%b Z=%b N=%b C=%b V=%b, want R=%b Z=%b N=%b C=%b V=%b",
               name, R, Z, N, C, V, r, z, n, c, v);
    end
  endtask
  task automatic load(input logic e, input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    en = e;
    S = s;
    A = a;
    B = b;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{3'b000, 4'b1010, 4'b0101, 4'b0000, 1, 0, 0, 0};
    tbl[1]  = '{3'b001, 4'b1010, 4'b0101, 4'b1111, 0, 1, 0, 0};
    tbl[2]  = '{3'b010, 4'b1010, 4'b0101, 4'b0101, 0, 0, 0, 0};
    tbl[3]  = '{3'b011, 4'b1010, 4'b0101, 4'b1111, 0, 1, 0, 0};
    tbl[4]  = '{3'b100, 4'b1010, 4'b0101, 4'b1111, 0, 1, 0, 0};
    tbl[5]  = '{3'b101, 4'b1010, 4'b0101, 4'b0101, 0, 0, 0, 1};
    tbl[6]  = '{3'b110, 4'b1010, 4'b0101, 4'b0100, 0, 0, 1, 0};
    tbl[7]  = '{3'b111, 4'b1010, 4'b0101, 4'b0101, 0, 0, 0, 0};
    tbl[8]  = '{3'b100, 4'b0111, 4'b0001, 4'b1000, 0, 1, 0, 1};
    tbl[9]  = '{3'b100, 4'b1111, 4'b0001, 4'b0000, 1, 0, 1, 0};
    tbl[10] = '{3'b101, 4'b0011, 4'b0101, 4'b1110, 0, 1, 1, 0};
    tbl[11] = '{3'b101, 4'b1000, 4'b0001, 4'b0111, 0, 0, 0, 1};
    tbl[12] = '{3'b111, 4'b0001, 4'b0000, 4'b0000, 1, 0, 1, 0};
    tbl[13] = '{3'b110, 4'b1000, 4'b0110, 4'b0000, 1, 0, 1, 0};
    en = 1'b1;
    A = 4'b1111;
    S = 3'b001;
    #2 rst = 1'b1;
    #1 check("reset_async", 4'b0000, 0, 0, 0, 0);
    @(posedge clk);
    #1 check("reset_held", 4'b0000, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      load(1'b1, tbl[i].s, tbl[i].a, tbl[i].b);
      check($sformatf("vec%0d", i), tbl[i].r, tbl[i].z, tbl[i].n, tbl[i].c, tbl[i].v);
    end
    load(1'b1, 3'b001, 4'b1111, 4'b0000);
    check("hold_load", 4'b1111, 0, 1, 0, 0);
    load(1'b0, 3'b000, 4'b0000, 4'b0000);
    check("hold_1", 4'b1111, 0, 1, 0, 0);
    load(1'b0, 3'b100, 4'b0111, 4'b0001);
    check("hold_2", 4'b1111, 0, 1, 0, 0);
    load(1'b0, 3'b110, 4'b1000, 4'b0011);
    check("hold_3", 4'b1111, 0, 1, 0, 0);
    #2 rst = 1'b1;
    #1 check("reset_mid", 4'b0000, 0, 0, 0, 0);
    @(negedge clk);
    en = 1'b1;
    S = 3'b100;
    A = 4'b0111;
    B = 4'b0001;
    @(posedge clk);
    #1 check("reset_beats_en", 4'b0000, 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1 check("first_after_reset", 4'b1000, 0, 1, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
